// File: rtl/vc_output_scheduler.sv
// Output-port scheduler: round-robin fill of one of two one-flit VC buffers
// while the other VC drains to the downstream link, selected by polarity.
module vc_output_scheduler #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          polarity,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_vc,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  input  logic                          ro,
  output logic                          so,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [NUM_REQ-1:0]            clear,
  output logic [NUM_REQ-1:0]            grant,
  output logic [1:0]                    empty
);

  logic [1:0]            r_bufV;
  logic [DATA_WIDTH-1:0] r_bufD0;
  logic [DATA_WIDTH-1:0] r_bufD1;
  logic [1:0]            r_ptr0;
  logic [1:0]            r_ptr1;

  logic                  w_fillVc;
  logic                  w_drainVc;
  logic                  w_fillFull;
  logic [1:0]            w_ptr;
  logic [NUM_REQ-1:0]    w_eligible;
  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_grantValid;
  logic [1:0]            w_sel;
  logic [1:0]            w_idx;
  logic                  w_so;
  logic [DATA_WIDTH-1:0] w_drainData;
  logic [DATA_WIDTH-1:0] w_fillData;

  assign w_fillVc   = ~polarity;
  assign w_drainVc  = polarity;
  assign w_fillFull = r_bufV[w_fillVc];
  assign w_ptr      = w_fillVc ? r_ptr1 : r_ptr0;

  // Reset gates everything so no stale buffer contents leak out during reset.
  assign w_eligible = req & ~(req_vc ^ {NUM_REQ{w_fillVc}})
                    & {NUM_REQ{~w_fillFull & ~reset}};

  always_comb begin
    w_grant      = '0;
    w_grantValid = 1'b0;
    w_sel        = '0;
    w_idx        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = w_ptr + 2'(i);
      if (!w_grantValid && w_eligible[w_idx]) begin
        w_grantValid = 1'b1;
        w_sel        = w_idx;
      end
    end
    if (w_grantValid) begin
      w_grant[w_sel] = 1'b1;
    end
  end

  assign w_fillData  = data_in[w_sel*DATA_WIDTH +: DATA_WIDTH];
  assign w_drainData = w_drainVc ? r_bufD1 : r_bufD0;
  assign w_so        = r_bufV[w_drainVc] & ro & ~reset;

  assign so       = w_so;
  assign data_out = w_so ? w_drainData : '0;
  assign grant    = w_grant;
  assign clear    = w_grant;
  assign empty    = reset ? 2'b11 : ~r_bufV;

  // Fill and drain always target opposite VCs, so both may update in one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bufV  <= 2'b00;
      r_bufD0 <= '0;
      r_bufD1 <= '0;
      r_ptr0  <= 2'd0;
      r_ptr1  <= 2'd0;
    end else begin
      if (w_grantValid) begin
        r_bufV[w_fillVc] <= 1'b1;
        if (w_fillVc) begin
          r_bufD1 <= w_fillData;
          r_ptr1  <= w_sel + 2'd1;
        end else begin
          r_bufD0 <= w_fillData;
          r_ptr0  <= w_sel + 2'd1;
        end
      end
      if (w_so) begin
        r_bufV[w_drainVc] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vc_output_scheduler.sv
// Directed self-checking bench for vc_output_scheduler with hand-computed expectations.
module tb_vc_output_scheduler;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          polarity = 1'b0;
  logic [3:0]    req = '0;
  logic [3:0]    reqVc = '0;
  logic [4*DW-1:0] dataIn = '0;
  logic          ro = 1'b0;
  logic          so;
  logic [DW-1:0] dataOut;
  logic [3:0]    clear;
  logic [3:0]    grant;
  logic [1:0]    empty;

  int checks = 0;
  int failures = 0;

  vc_output_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .req      (req),
    .req_vc   (reqVc),
    .data_in  (dataIn),
    .ro       (ro),
    .so       (so),
    .data_out (dataOut),
    .clear    (clear),
    .grant    (grant),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic rst, input logic pol, input logic [3:0] rq,
                               input logic [3:0] rv, input logic r);
    @(negedge clk);
    reset    = rst;
    polarity = pol;
    req      = rq;
    reqVc    = rv;
    ro       = r;
    #1;
  endtask

  task automatic setLanes(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    dataIn = {d3, d2, d1, d0};
  endtask

  task automatic checkOutput(input string tag, input logic expSo, input logic [DW-1:0] expData,
                             input logic [3:0] expGrant, input logic [1:0] expEmpty);
    checks++;
    assert (so === expSo) else begin
      failures++;
      $error("FAIL %s so: observed %0b expected %0b", tag, so, expSo);
    end
    checks++;
    assert (dataOut === expData) else begin
      failures++;
      $error("FAIL %s data_out: observed %h expected %h", tag, dataOut, expData);
    end
    checks++;
    assert (grant === expGrant) else begin
      failures++;
      $error("FAIL %s grant: observed %b expected %b", tag, grant, expGrant);
    end
    checks++;
    assert (clear === expGrant) else begin
      failures++;
      $error("FAIL %s clear: observed %b expected %b", tag, clear, expGrant);
    end
    checks++;
    assert (empty === expEmpty) else begin
      failures++;
      $error("FAIL %s empty: observed %b expected %b", tag, empty, expEmpty);
    end
  endtask

  initial begin
    // Reset and idle
    applyStimulus(1, 0, 4'b0000, 4'b0000, 0); checkOutput("rst0", 0, 64'h0, 4'b0000, 2'b11);
    applyStimulus(1, 1, 4'b0000, 4'b0000, 0); checkOutput("rst1", 0, 64'h0, 4'b0000, 2'b11);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, i[0], 4'b0000, 4'b0000, 1);
      checkOutput("idle", 0, 64'h0, 4'b0000, 2'b11);
    end

    // Single flit on the odd VC; leaves ptr1 at 2
    setLanes(64'h0, 64'hA5, 64'h0, 64'h0);
    applyStimulus(0, 0, 4'b0010, 4'b1111, 1); checkOutput("single_grant", 0, 64'h0, 4'b0010, 2'b11);
    applyStimulus(0, 1, 4'b0000, 4'b1111, 1); checkOutput("single_send", 1, 64'hA5, 4'b0000, 2'b01);
    applyStimulus(0, 0, 4'b0000, 4'b0000, 1); checkOutput("single_empty", 0, 64'h0, 4'b0000, 2'b11);

    // Round robin on the even VC: 0001,0010,0100,1000,0001
    setLanes(64'h100, 64'h101, 64'h102, 64'h103);
    applyStimulus(0, 1, 4'b1111, 4'b0000, 1); checkOutput("rr_g0", 0, 64'h0, 4'b0001, 2'b11);
    applyStimulus(0, 0, 4'b1111, 4'b0000, 1); checkOutput("rr_d0", 1, 64'h100, 4'b0000, 2'b10);
    applyStimulus(0, 1, 4'b1111, 4'b0000, 1); checkOutput("rr_g1", 0, 64'h0, 4'b0010, 2'b11);
    applyStimulus(0, 0, 4'b1111, 4'b0000, 1); checkOutput("rr_d1", 1, 64'h101, 4'b0000, 2'b10);
    applyStimulus(0, 1, 4'b1111, 4'b0000, 1); checkOutput("rr_g2", 0, 64'h0, 4'b0100, 2'b11);
    applyStimulus(0, 0, 4'b1111, 4'b0000, 1); checkOutput("rr_d2", 1, 64'h102, 4'b0000, 2'b10);
    applyStimulus(0, 1, 4'b1111, 4'b0000, 1); checkOutput("rr_g3", 0, 64'h0, 4'b1000, 2'b11);
    applyStimulus(0, 0, 4'b1111, 4'b0000, 1); checkOutput("rr_d3", 1, 64'h103, 4'b0000, 2'b10);
    applyStimulus(0, 1, 4'b1111, 4'b0000, 1); checkOutput("rr_wrap", 0, 64'h0, 4'b0001, 2'b11);
    applyStimulus(0, 0, 4'b1111, 4'b0000, 1); checkOutput("rr_d4", 1, 64'h100, 4'b0000, 2'b10);
    // Odd pointer untouched by even fills: still 2 from the single flit
    applyStimulus(0, 1, 4'b0000, 4'b0000, 1); checkOutput("rr_gap", 0, 64'h0, 4'b0000, 2'b11);
    applyStimulus(0, 0, 4'b1111, 4'b1111, 1); checkOutput("rr_odd_ptr", 0, 64'h0, 4'b0100, 2'b11);
    applyStimulus(0, 1, 4'b0000, 4'b0000, 1); checkOutput("rr_odd_send", 1, 64'h102, 4'b0000, 2'b01);

    // Backpressure on the even VC (ptr0=1, ptr1=3)
    setLanes(64'h11, 64'h22, 64'h0, 64'h0);
    applyStimulus(0, 1, 4'b0001, 4'b0000, 0); checkOutput("bp_fill", 0, 64'h0, 4'b0001, 2'b11);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 4'b0010, 4'b0000, 0); checkOutput("bp_hold", 0, 64'h0, 4'b0000, 2'b10);
      applyStimulus(0, 1, 4'b0010, 4'b0000, 0); checkOutput("bp_full", 0, 64'h0, 4'b0000, 2'b10);
    end
    applyStimulus(0, 0, 4'b0010, 4'b0000, 1); checkOutput("bp_release", 1, 64'h11, 4'b0000, 2'b10);
    applyStimulus(0, 1, 4'b0010, 4'b0000, 1); checkOutput("bp_refill", 0, 64'h0, 4'b0010, 2'b11);
    applyStimulus(0, 0, 4'b0000, 4'b0000, 1); checkOutput("bp_send2", 1, 64'h22, 4'b0000, 2'b10);

    // Concurrent VCs (ptr0=2, ptr1=3)
    setLanes(64'h0, 64'h0, 64'hBB, 64'hCC);
    applyStimulus(0, 0, 4'b0100, 4'b0100, 1); checkOutput("cc_fill_odd", 0, 64'h0, 4'b0100, 2'b11);
    applyStimulus(0, 1, 4'b1000, 4'b0000, 1); checkOutput("cc_both", 1, 64'hBB, 4'b1000, 2'b01);
    applyStimulus(0, 0, 4'b0000, 4'b0000, 1); checkOutput("cc_send_even", 1, 64'hCC, 4'b0000, 2'b10);

    // Mid-operation reset with both buffers full (ptr0=0, ptr1=3 before fills)
    setLanes(64'hD0, 64'h0, 64'h0, 64'h0);
    applyStimulus(0, 1, 4'b0001, 4'b0000, 0); checkOutput("mr_fill_even", 0, 64'h0, 4'b0001, 2'b11);
    setLanes(64'hD1, 64'h0, 64'h0, 64'h0);
    applyStimulus(0, 0, 4'b0001, 4'b0001, 0); checkOutput("mr_fill_odd", 0, 64'h0, 4'b0001, 2'b10);
    applyStimulus(0, 1, 4'b0000, 4'b0000, 0); checkOutput("mr_full", 0, 64'h0, 4'b0000, 2'b00);
    applyStimulus(1, 1, 4'b0000, 4'b0000, 1); checkOutput("mr_in_reset", 0, 64'h0, 4'b0000, 2'b11);
    applyStimulus(0, 0, 4'b0000, 4'b0000, 1); checkOutput("mr_after0", 0, 64'h0, 4'b0000, 2'b11);
    applyStimulus(0, 1, 4'b0000, 4'b0000, 1); checkOutput("mr_after1", 0, 64'h0, 4'b0000, 2'b11);
    // Without the reset both pointers would be 1 here and pick requester 1
    setLanes(64'hE0, 64'hE1, 64'hE2, 64'hE3);
    applyStimulus(0, 1, 4'b1111, 4'b0000, 1); checkOutput("mr_ptr0", 0, 64'h0, 4'b0001, 2'b11);
    applyStimulus(0, 0, 4'b1111, 4'b1111, 1); checkOutput("mr_ptr1", 1, 64'hE0, 4'b0001, 2'b10);
    applyStimulus(0, 1, 4'b0000, 4'b0000, 1); checkOutput("mr_tail", 1, 64'hE0, 4'b0000, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
